pipeexe_mdu: RTL and testbench

- Parametrised execute stage for the pipelined MIPS core.
- Keeps the existing single-cycle ALU path: shift-amount and immediate operand muxes, JAL link address, and link-register forcing.
- Adds an iterative multiply/divide unit (MDU) with HI/LO registers and mfhi/mflo/mthi/mtlo.
- Drives a stall request to the hazard unit while an MDU result is pending.

---
 rtl/pipe_pkg.sv | 41 ++++
 rtl/pipeexe_mdu_if.sv | 24 ++
 rtl/alu.sv | 32 +++
 rtl/mdu_iter.sv | 110 +++++++++++
 rtl/pipeexe_mdu.sv | 78 +++++++
 tb/tb_pipeexe_mdu.sv | 313 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined execute stage: MDU op codes,
// ALU function codes, link register and the MDU sequencer state.
package pipe_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  // Canonical ALU codes; bit 3 is a don't-care for all but the shifts.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam int REG_LINK = 31;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_t;

  typedef struct packed {
    logic is_div;
    logic neg_q;
    logic neg_r;
    logic dz;
  } mdu_flags_t;

endpackage

// File: rtl/pipeexe_mdu_if.sv
// Execute-stage bus: decoded operands/controls in, result/stall out.
interface pipeexe_mdu_if #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
);
  logic [WIDTH-1:0] ea, eb, eimm, epc4;
  logic [RADDR-1:0] ern0;
  logic [3:0]       ealuc;
  logic             ealuimm, eshift, ejal;
  logic [3:0]       emdop;
  logic [WIDTH-1:0] ealu;
  logic [RADDR-1:0] ern;
  logic             estall, mdu_busy;

  modport master (
    output ea, eb, eimm, epc4, ern0, ealuc, ealuimm, eshift, ejal, emdop,
    input  ealu, ern, estall, mdu_busy
  );

  modport slave (
    input  ea, eb, eimm, epc4, ern0, ealuc, ealuimm, eshift, ejal, emdop,
    output ealu, ern, estall, mdu_busy
  );
endinterface

// File: rtl/alu.sv
// Single-cycle ALU; shifts take the amount from the low bits of a.
module alu
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic [WIDTH-1:0] r
);
  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0] sh;
  assign sh = a[SW-1:0];

  always_comb begin
    r = '0;
    casez (aluc)
      4'b?000: r = a + b;
      4'b?100: r = a - b;
      4'b?001: r = a & b;
      4'b?101: r = a | b;
      4'b?010: r = a ^ b;
      4'b?110: r = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'b0011: r = b << sh;
      4'b0111: r = b >> sh;
      4'b1111: r = $signed(b) >>> sh;
      default: r = '0;
    endcase
  end
endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide: sign-magnitude in, WIDTH shift-add or
// restoring-divide steps, then one FIX cycle that applies signs.
module mdu_iter
  import pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit HAS_DIV = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);
  localparam int CW = $clog2(WIDTH);

  mdu_state_t         state, state_n;
  mdu_flags_t         fl;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   d;
  logic [2*WIDTH-1:0] acc, acc_n, prod;
  logic               sgn, sa, sb, div_sel;
  logic [WIDTH-1:0]   ma, mb, q, r;
  logic [WIDTH:0]     mul_sum, shr, trial;

  always_comb begin
    sgn     = (op == MD_MULT) || (op == MD_DIV);
    sa      = sgn & a[WIDTH-1];
    sb      = sgn & b[WIDTH-1];
    ma      = sa ? -a : a;
    mb      = sb ? -b : b;
    div_sel = HAS_DIV && ((op == MD_DIV) || (op == MD_DIVU));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= MDU_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      MDU_IDLE: if (start) state_n = MDU_BUSY;
      MDU_BUSY: if (cnt == CW'(WIDTH-1)) state_n = MDU_FIX;
      MDU_FIX:  state_n = MDU_IDLE;
      default:  state_n = MDU_IDLE;
    endcase
  end

  assign busy = (state != MDU_IDLE);
  assign done = (state == MDU_FIX);

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, d} : '0);
    shr     = acc[2*WIDTH-1:WIDTH-1];
    trial   = shr - {1'b0, d};
    if (HAS_DIV && fl.is_div)
      acc_n = {trial[WIDTH] ? shr[WIDTH-1:0] : trial[WIDTH-1:0],
               acc[WIDTH-2:0], ~trial[WIDTH]};
    else
      acc_n = {mul_sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      d   <= '0;
      acc <= '0;
      fl  <= '0;
    end else begin
      case (state)
        MDU_IDLE: if (start) begin
          cnt       <= '0;
          d         <= div_sel ? mb : ma;
          acc       <= {{WIDTH{1'b0}}, div_sel ? ma : mb};
          fl.is_div <= div_sel;
          fl.neg_q  <= sa ^ sb;
          fl.neg_r  <= sa;
          fl.dz     <= (b == '0);
        end
        MDU_BUSY: begin
          acc <= acc_n;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Divide by zero: raw quotient is all-ones and remainder is |a|, so
  // only LO needs overriding; negating |a| restores the signed dividend.
  always_comb begin
    prod = fl.neg_q ? -acc : acc;
    q    = fl.neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r    = fl.neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    if (fl.is_div) begin
      hi_out = r;
      lo_out = fl.dz ? '1 : q;
    end else begin
      hi_out = prod[2*WIDTH-1:WIDTH];
      lo_out = prod[WIDTH-1:0];
    end
  end
endmodule

// File: rtl/pipeexe_mdu.sv
// Execute stage: operand muxes, ALU, JAL link, HI/LO and the MDU with
// its stall request toward the hazard unit.
module pipeexe_mdu
  import pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RADDR   = 5,
  parameter bit HAS_DIV = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  pipeexe_mdu_if.slave  e
);
  logic [WIDTH-1:0] shamt, alua, alub, alur, hi, lo, hi_new, lo_new;
  logic             busy, done, start, div_op, mdu_op, stall_op;

  generate
    if (WIDTH >= 11) begin : g_sh
      assign shamt = {{(WIDTH-5){1'b0}}, e.eimm[10:6]};
    end else begin : g_sh_none
      assign shamt = '0;
    end
  endgenerate

  assign alua = e.eshift ? shamt : e.ea;
  assign alub = e.ealuimm ? e.eimm : e.eb;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a    (alua),
    .b    (alub),
    .aluc (e.ealuc),
    .r    (alur)
  );

  // Without a divider div/divu are plain no-ops and must never stall.
  assign div_op   = HAS_DIV && ((e.emdop == MD_DIV) || (e.emdop == MD_DIVU));
  assign mdu_op   = (e.emdop == MD_MULT) || (e.emdop == MD_MULTU) || div_op;
  assign stall_op = mdu_op || ((e.emdop >= MD_MFHI) && (e.emdop <= MD_MTLO));
  assign start    = !busy && mdu_op;

  assign e.estall   = busy && stall_op;
  assign e.mdu_busy = busy;

  mdu_iter #(.WIDTH(WIDTH), .HAS_DIV(HAS_DIV)) u_mdu (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (e.emdop),
    .a      (e.ea),
    .b      (e.eb),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_new),
    .lo_out (lo_new)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      hi <= hi_new;
      lo <= lo_new;
    end else if (!busy) begin
      if (e.emdop == MD_MTHI) hi <= e.ea;
      if (e.emdop == MD_MTLO) lo <= e.ea;
    end
  end

  always_comb begin
    if (e.ejal)                    e.ealu = e.epc4 + WIDTH'(4);
    else if (e.emdop == MD_MFHI)   e.ealu = hi;
    else if (e.emdop == MD_MFLO)   e.ealu = lo;
    else                           e.ealu = alur;
  end

  assign e.ern = e.ern0 | {RADDR{e.ejal}};
endmodule

// File: tb/tb_pipeexe_mdu.sv
// Drives a 32-bit and a 16-bit execute stage with the same stimulus and
// checks both against an arithmetic reference of the ALU and MDU.
module tb_pipeexe_mdu;
  import pipe_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ea, eb, eimm, epc4;
  logic [4:0]  ern0;
  logic [3:0]  ealuc, emdop;
  logic        ealuimm, eshift, ejal;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mhi[2];
  logic [31:0] mlo[2];

  always #5 clock = ~clock;

  pipeexe_mdu_if #(.WIDTH(32), .RADDR(5)) b32 ();
  pipeexe_mdu_if #(.WIDTH(16), .RADDR(5)) b16 ();

  assign b32.ea = ea;          assign b16.ea = ea[15:0];
  assign b32.eb = eb;          assign b16.eb = eb[15:0];
  assign b32.eimm = eimm;      assign b16.eimm = eimm[15:0];
  assign b32.epc4 = epc4;      assign b16.epc4 = epc4[15:0];
  assign b32.ern0 = ern0;      assign b16.ern0 = ern0;
  assign b32.ealuc = ealuc;    assign b16.ealuc = ealuc;
  assign b32.ealuimm = ealuimm; assign b16.ealuimm = ealuimm;
  assign b32.eshift = eshift;  assign b16.eshift = eshift;
  assign b32.ejal = ejal;      assign b16.ejal = ejal;
  assign b32.emdop = emdop;    assign b16.emdop = emdop;

  pipeexe_mdu #(.WIDTH(32), .RADDR(5), .HAS_DIV(1'b1)) dut32 (
    .clock (clock), .reset (reset), .e (b32));
  pipeexe_mdu #(.WIDTH(16), .RADDR(5), .HAS_DIV(1'b1)) dut16 (
    .clock (clock), .reset (reset), .e (b16));

  function automatic int wof(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic logic [31:0] g_alu(int k);
    return (k == 0) ? b32.ealu : {16'h0, b16.ealu};
  endfunction

  function automatic logic [31:0] g_ern(int k);
    return (k == 0) ? {27'h0, b32.ern} : {27'h0, b16.ern};
  endfunction

  function automatic logic g_stall(int k);
    return (k == 0) ? b32.estall : b16.estall;
  endfunction

  function automatic logic g_busy(int k);
    return (k == 0) ? b32.mdu_busy : b16.mdu_busy;
  endfunction

  function automatic logic [63:0] mask(int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint sx(logic [31:0] x, int w);
    longint v;
    v = longint'({32'h0, x});
    v = v <<< (64 - w);
    return v >>> (64 - w);
  endfunction

  function automatic logic [31:0] alu_ref(logic [3:0] c, logic [31:0] a, logic [31:0] b, int w);
    logic [63:0] r, a6, b6;
    int          sh;
    a6 = {32'h0, a};
    b6 = {32'h0, b};
    sh = int'(a & 32'(w - 1));
    case (c)
      ALU_ADD: r = a6 + b6;
      ALU_SUB: r = a6 - b6;
      ALU_AND: r = a6 & b6;
      ALU_OR:  r = a6 | b6;
      ALU_XOR: r = a6 ^ b6;
      ALU_LUI: r = b6 << (w / 2);
      ALU_SLL: r = b6 << sh;
      ALU_SRL: r = (b6 & mask(w)) >> sh;
      ALU_SRA: r = 64'(sx(b, w) >>> sh);
      default: r = 64'h0;
    endcase
    return 32'(r & mask(w));
  endfunction

  task automatic mdu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int w, output logic [31:0] hi, output logic [31:0] lo);
    logic [63:0] m, ua, ub, p;
    longint      sa, sb;
    m  = mask(w);
    ua = {32'h0, a} & m;
    ub = {32'h0, b} & m;
    sa = sx(a, w);
    sb = sx(b, w);
    hi = '0;
    lo = '0;
    case (op)
      MD_MULT, MD_MULTU: begin
        p  = (op == MD_MULT) ? 64'(sa * sb) : ua * ub;
        hi = 32'((p >> w) & m);
        lo = 32'(p & m);
      end
      MD_DIV: begin
        if (sb == 0) begin lo = 32'(m); hi = 32'(ua); end
        else begin lo = 32'(64'(sa / sb) & m); hi = 32'(64'(sa % sb) & m); end
      end
      MD_DIVU: begin
        if (ub == 0) begin lo = 32'(m); hi = 32'(ua); end
        else begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    ea = '0; eb = '0; eimm = '0; epc4 = '0; ern0 = '0;
    ealuc = ALU_ADD; ealuimm = 1'b0; eshift = 1'b0; ejal = 1'b0; emdop = MD_NONE;
  endtask

  task automatic check_alu(input string tag);
    logic [31:0] aa, bb, ex;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      aa = eshift ? {27'h0, eimm[10:6]} : ea;
      bb = ealuimm ? eimm : eb;
      ex = ejal ? 32'((({32'h0, epc4} + 64'd4)) & mask(wof(k)))
                : alu_ref(ealuc, aa, bb, wof(k));
      chk({tag, "_alu"}, g_alu(k), ex);
      chk({tag, "_rn"}, g_ern(k), {27'h0, ejal ? 5'd31 : ern0});
      chk({tag, "_stall"}, {31'h0, g_stall(k)}, 32'h0);
    end
    step();
  endtask

  task automatic read_hilo(input string tag);
    emdop = MD_MFHI;
    @(negedge clock);
    for (int k = 0; k < 2; k++) chk({tag, "_mfhi"}, g_alu(k), mhi[k]);
    step();
    emdop = MD_MFLO;
    @(negedge clock);
    for (int k = 0; k < 2; k++) chk({tag, "_mflo"}, g_alu(k), mlo[k]);
    step();
    emdop = MD_NONE;
  endtask

  task automatic run_mdu(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          c[2];
    logic [31:0] h, l;
    ea = a; eb = b; emdop = op;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_issue_stall"}, {31'h0, g_stall(k)}, 32'h0);
      mdu_model(op, a, b, wof(k), h, l);
      mhi[k] = h;
      mlo[k] = l;
    end
    step();
    emdop = MD_MFHI;
    c[0] = 0;
    c[1] = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      for (int k = 0; k < 2; k++) if (g_stall(k)) c[k]++;
      if (!g_stall(0) && !g_stall(1)) break;
    end
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_latency"}, 32'(c[k]), 32'(wof(k) + 1));
      chk({tag, "_mfhi"}, g_alu(k), mhi[k]);
    end
    step();
    emdop = MD_MFLO;
    @(negedge clock);
    for (int k = 0; k < 2; k++) chk({tag, "_mflo"}, g_alu(k), mlo[k]);
    step();
    emdop = MD_NONE;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] codes[9];
    logic [31:0] a, b;
    codes = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA};
    idle_in();
    mhi = '{32'h0, 32'h0};
    mlo = '{32'h0, 32'h0};

    // Reset state: MDU idle, no stall, HI reads zero.
    emdop = MD_MFHI;
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", {31'h0, g_busy(k)}, 32'h0);
      chk("rst_stall", {31'h0, g_stall(k)}, 32'h0);
      chk("rst_hi", g_alu(k), 32'h0);
    end
    step();
    reset = 1'b0;
    emdop = MD_NONE;

    ealuc = ALU_ADD; ea = 32'd5; eb = 32'd7;
    check_alu("add");
    eshift = 1'b1; eimm = 32'd4 << 6; ealuc = ALU_SLL; eb = 32'd1;
    check_alu("sll");
    idle_in();
    ejal = 1'b1; epc4 = 32'h0040_0008; ern0 = 5'd0;
    check_alu("jal");

    for (int i = 0; i < 12; i++) begin
      ealuc = codes[$urandom_range(0, 8)];
      ea = $urandom; eb = $urandom; eimm = $urandom; epc4 = $urandom;
      ealuimm = 1'($urandom_range(0, 1));
      eshift = 1'($urandom_range(0, 1));
      ejal = ($urandom_range(0, 4) == 0);
      ern0 = 5'($urandom_range(0, 31));
      check_alu("alu_rnd");
    end
    idle_in();

    run_mdu("mult_neg", MD_MULT, -32'sd3, 32'd5);
    run_mdu("div_neg", MD_DIV, -32'sd7, 32'd2);
    run_mdu("divu", MD_DIVU, 32'd100, 32'd7);
    run_mdu("divu_z", MD_DIVU, 32'h1234, 32'h0);
    run_mdu("div_z", MD_DIV, 32'hFFFF_8001, 32'h0);
    run_mdu("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_mdu("multu", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 20));
        2: begin a = 32'hFFFF_8000; b = 32'hFFFF_FFFF; end
        default: b = $urandom;
      endcase
      run_mdu("mdu_rnd", 4'($urandom_range(1, 4)), a, b);
    end

    ea = $urandom; emdop = MD_MTHI;
    mhi[0] = ea; mhi[1] = {16'h0, ea[15:0]};
    step();
    ea = $urandom; emdop = MD_MTLO;
    mlo[0] = ea; mlo[1] = {16'h0, ea[15:0]};
    step();
    emdop = MD_NONE;
    read_hilo("mtx");

    // Plain ALU ops keep flowing while the MDU iterates.
    ea = 32'd11; eb = 32'd13; emdop = MD_MULT;
    for (int k = 0; k < 2; k++) mdu_model(MD_MULT, ea, eb, wof(k), mhi[k], mlo[k]);
    step();
    emdop = MD_NONE;
    for (int i = 0; i < 5; i++) begin
      ealuc = ALU_ADD; ea = $urandom; eb = $urandom;
      @(negedge clock);
      for (int k = 0; k < 2; k++) chk("flow_busy", {31'h0, g_busy(k)}, 32'h1);
      check_alu("flow");
    end
    idle_in();
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      if (!g_busy(0) && !g_busy(1)) break;
      step();
    end
    read_hilo("flow");

    // Reset in the middle of BUSY aborts the op and clears HI/LO.
    ea = 32'hDEAD_BEEF; emdop = MD_MTHI; step();
    emdop = MD_MTLO; step();
    ea = 32'd123; eb = 32'd456; emdop = MD_MULT; step();
    emdop = MD_NONE;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    emdop = MD_MFHI;
    mhi = '{32'h0, 32'h0};
    mlo = '{32'h0, 32'h0};
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk("abort_busy", {31'h0, g_busy(k)}, 32'h0);
      chk("abort_hi", g_alu(k), 32'h0);
    end
    step();
    reset = 1'b0;
    emdop = MD_NONE;
    read_hilo("abort");
    run_mdu("post_rst", MD_MULT, -32'sd3, 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
